wb_arbiter2: RTL

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter2.sv
// wb_arbiter2 -- two-master Wishbone arbiter with per-transfer watchdog.
//   m0_* : master 0 (core data port)       m1_* : master 1 (UART loader / DMA)
//   s_*  : shared slave (data memory)      grant_o : one-hot owner (01=m0, 10=m1)
// Ownership is held for the full cyc_i so locked/burst cycles are never split;
// every handover goes through one IDLE cycle. Ties from IDLE are round-robin.
// A watchdog counts unanswered strobe cycles; on reaching TIMEOUT it errors
// the owner for one cycle and drops s_cyc_o/s_stb_o for that cycle.
module wb_arbiter2 #(
  parameter int ADR_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  // master 0
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  input  logic [3:0]       m0_sel_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [31:0]      m0_dat_o,
  // master 1
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  input  logic [3:0]       m1_sel_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [31:0]      m1_dat_o,
  // slave
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [3:0]       s_sel_o,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic [31:0]      s_dat_i,
  // arbitration status
  output logic [1:0]       grant_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          last1;          // 1: m1 was granted most recently
  logic [CW-1:0] wd_cnt, wd_cnt_nxt;
  logic          own_stb;
  logic          to_fire;        // watchdog expiry this cycle (ack wins over it)

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      last1  <= 1'b1;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_cnt_nxt;
      if (state_nxt == OWN0)      last1 <= 1'b0;
      else if (state_nxt == OWN1) last1 <= 1'b1;
    end
  end

  // Next state: no direct OWN0<->OWN1 path, so a handover always costs one IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last1 ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_nxt = OWN0;
        else if (m1_cyc_i)        state_nxt = OWN1;
      end
      OWN0:    if (!m0_cyc_i) state_nxt = IDLE;
      OWN1:    if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog
  always_comb begin
    own_stb = 1'b0;
    if (state == OWN0)      own_stb = m0_stb_i;
    else if (state == OWN1) own_stb = m1_stb_i;
    to_fire = (wd_cnt == TO_CNT) && !s_ack_i;
    if (state == IDLE || state_nxt == IDLE || !own_stb ||
        s_ack_i || s_err_i || wd_cnt == TO_CNT)
      wd_cnt_nxt = '0;
    else
      wd_cnt_nxt = wd_cnt + 1'b1;
  end

  // Request/response muxing; everything defaults to zero so IDLE and the
  // non-owner see a quiet bus.
  always_comb begin
    grant_o  = 2'b00;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    case (state)
      OWN0: begin
        grant_o  = 2'b01;
        s_cyc_o  = m0_cyc_i & ~to_fire;
        s_stb_o  = m0_stb_i & ~to_fire;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | to_fire;
        m0_dat_o = s_dat_i;
      end
      OWN1: begin
        grant_o  = 2'b10;
        s_cyc_o  = m1_cyc_i & ~to_fire;
        s_stb_o  = m1_stb_i & ~to_fire;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | to_fire;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

endmodule
